ce_frac_gen: RTL and testbench

Parametrised multi-channel fractional clock-enable generator. It replaces the fixed 2-bit and mod-6 counters in the arcade top level that derive pixel and CPU enables from `clk_sys`. Each channel emits single-cycle enables at `clk_sys*NUM/DEN`. Ratios are reprogrammable at run time per game ID, switch glitch-free at a period boundary, and all channels freeze on pause.

---
 rtl/cosmic_clk_pkg.sv | 27 ++
 rtl/ce_frac_channel.sv | 94 +++++++++
 rtl/ce_frac_gen.sv | 50 +++++
 tb/tb_ce_frac_gen.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cosmic_clk_pkg.sv
// Shared clock-enable definitions for the arcade top level.
// Holds the default accumulator width, the standard pixel/CPU enable
// ratios and the game-ID to CPU-ratio mapping.
package cosmic_clk_pkg;

    localparam int unsigned ACC_W_DEF = 8;
    localparam int unsigned GAME_ID_W = 8;

    // Enable ratio: pulses at clk_sys * num / den
    typedef struct packed {
        logic [ACC_W_DEF-1:0] num;
        logic [ACC_W_DEF-1:0] den;
    } ce_ratio_t;

    localparam ce_ratio_t CE_PIX    = '{num: ACC_W_DEF'(1), den: ACC_W_DEF'(2)};
    localparam ce_ratio_t CE_CPU_27 = '{num: ACC_W_DEF'(1), den: ACC_W_DEF'(4)};
    localparam ce_ratio_t CE_CPU_18 = '{num: ACC_W_DEF'(1), den: ACC_W_DEF'(6)};

    // Games 2 and 4 run the CPU at 1/4, every other title at 1/6
    function automatic ce_ratio_t cpu_ratio(input logic [GAME_ID_W-1:0] game_id);
        case (game_id)
            GAME_ID_W'(2), GAME_ID_W'(4): return CE_CPU_27;
            default:                      return CE_CPU_18;
        endcase
    endfunction

endpackage

// File: rtl/ce_frac_channel.sv
// One fractional clock-enable channel (Bresenham accumulator).
// Ports:
//   clk_sys, reset        - clock, synchronous active-high reset
//   pause, align          - freeze / zero the accumulator
//   cfg_load, cfg_num/den - capture a new ratio into the pending register
//   ce                    - registered single-cycle enable pulse
//   pend                  - pending ratio not yet applied
//   cfg_err               - active ratio invalid, channel silent
module ce_frac_channel
    import cosmic_clk_pkg::*;
#(
    parameter int unsigned ACC_W   = ACC_W_DEF,
    parameter int unsigned DEF_NUM = 1,
    parameter int unsigned DEF_DEN = 6
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             pause,
    input  logic             align,
    input  logic             cfg_load,
    input  logic [ACC_W-1:0] cfg_num,
    input  logic [ACC_W-1:0] cfg_den,
    output logic             ce,
    output logic             pend,
    output logic             cfg_err
);

    localparam logic [ACC_W-1:0] DEF_NUM_W = ACC_W'(DEF_NUM);
    localparam logic [ACC_W-1:0] DEF_DEN_W = ACC_W'(DEF_DEN);
    localparam logic             DEF_ERR   = (DEF_DEN == 0) || (DEF_NUM > DEF_DEN);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] num;
    logic [ACC_W-1:0] den;
    logic [ACC_W-1:0] pnum;
    logic [ACC_W-1:0] pden;

    logic [ACC_W:0]   sum_c;
    logic             cross_c;
    logic             idle_c;
    logic             apply_c;
    logic             pend_err_c;
    logic [ACC_W-1:0] acc_nxt_c;

    // Crossing detect and pending-application decision
    always_comb begin
        sum_c      = {1'b0, acc} + {1'b0, num};
        cross_c    = !pause && !cfg_err && (sum_c >= {1'b0, den});
        idle_c     = cfg_err || (num == '0);
        apply_c    = pend && (cross_c || idle_c || align);
        pend_err_c = (pden == '0) || (pnum > pden);
    end

    // Next accumulator: a realign or a new ratio restarts the period from 0
    always_comb begin
        acc_nxt_c = acc;
        if (apply_c || align || cfg_err) begin
            acc_nxt_c = '0;
        end else if (!pause) begin
            acc_nxt_c = cross_c ? ACC_W'(sum_c - {1'b0, den}) : ACC_W'(sum_c);
        end
    end

    // Channel state registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            acc     <= '0;
            num     <= DEF_NUM_W;
            den     <= DEF_DEN_W;
            pnum    <= DEF_NUM_W;
            pden    <= DEF_DEN_W;
            pend    <= 1'b0;
            cfg_err <= DEF_ERR;
            ce      <= 1'b0;
        end else begin
            ce  <= cross_c;
            acc <= acc_nxt_c;
            if (apply_c) begin
                num     <= pnum;
                den     <= pden;
                cfg_err <= pend_err_c;
            end
            // A load in the same cycle as an application queues behind it
            if (cfg_load) begin
                pnum <= cfg_num;
                pden <= cfg_den;
                pend <= 1'b1;
            end else if (apply_c) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ce_frac_gen.sv
// Multi-channel fractional clock-enable generator.
// Each channel emits single-cycle enables at clk_sys*NUM/DEN.
// Ports:
//   clk_sys, reset        - clock, synchronous active-high reset
//   pause                 - freeze all channels, enables low
//   align                 - zero every accumulator (phase realign)
//   cfg_load[NUM_CH]      - per-channel capture of cfg_num/cfg_den slices
//   cfg_num, cfg_den      - channel i at [i*ACC_W +: ACC_W]
//   ce, pend, cfg_err     - per-channel enable, pending flag, config error
module ce_frac_gen
    import cosmic_clk_pkg::*;
#(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned ACC_W   = ACC_W_DEF,
    parameter int unsigned DEF_NUM = 1,
    parameter int unsigned DEF_DEN = 6
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    pause,
    input  logic                    align,
    input  logic [NUM_CH-1:0]       cfg_load,
    input  logic [NUM_CH*ACC_W-1:0] cfg_num,
    input  logic [NUM_CH*ACC_W-1:0] cfg_den,
    output logic [NUM_CH-1:0]       ce,
    output logic [NUM_CH-1:0]       pend,
    output logic [NUM_CH-1:0]       cfg_err
);

    // One channel per enable output
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ce_frac_channel #(
            .ACC_W   (ACC_W),
            .DEF_NUM (DEF_NUM),
            .DEF_DEN (DEF_DEN)
        ) u_ch (
            .clk_sys  (clk_sys),
            .reset    (reset),
            .pause    (pause),
            .align    (align),
            .cfg_load (cfg_load[i]),
            .cfg_num  (cfg_num[i*ACC_W +: ACC_W]),
            .cfg_den  (cfg_den[i*ACC_W +: ACC_W]),
            .ce       (ce[i]),
            .pend     (pend[i]),
            .cfg_err  (cfg_err[i])
        );
    end

endmodule

// File: tb/tb_ce_frac_gen.sv
// Directed bench for ce_frac_gen (2 channels, 8-bit accumulators, default 1/6).
module tb_ce_frac_gen;

    logic        clk_sys;
    logic        reset;
    logic        pause;
    logic        align;
    logic [1:0]  cfg_load;
    logic [15:0] cfg_num;
    logic [15:0] cfg_den;
    logic [1:0]  ce;
    logic [1:0]  pend;
    logic [1:0]  cfg_err;

    int n_cmp;
    int n_fail;

    ce_frac_gen #(
        .NUM_CH  (2),
        .ACC_W   (8),
        .DEF_NUM (1),
        .DEF_DEN (6)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .pause    (pause),
        .align    (align),
        .cfg_load (cfg_load),
        .cfg_num  (cfg_num),
        .cfg_den  (cfg_den),
        .ce       (ce),
        .pend     (pend),
        .cfg_err  (cfg_err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Advance one clock; outputs are then stable and inputs may change
    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        pause    = 1'b0;
        align    = 1'b0;
        cfg_load = 2'b00;
        step();
        step();
        reset = 1'b0;
    endtask

    // Load a ratio and apply it immediately with an align pulse
    task automatic load_apply(input logic [1:0] mask, input logic [15:0] nums,
                              input logic [15:0] dens);
        cfg_num  = nums;
        cfg_den  = dens;
        cfg_load = mask;
        step();
        cfg_load = 2'b00;
        align    = 1'b1;
        step();
        align    = 1'b0;
    endtask

    task automatic test_reset();
        logic [1:0] exp;
        reset    = 1'b1;
        pause    = 1'b1;
        align    = 1'b1;
        cfg_load = 2'b11;
        cfg_num  = 16'h0305;
        cfg_den  = 16'h0000;
        step();
        step();
        n_cmp++;
        if ({ce, pend, cfg_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_state: ce/pend/err=%b required 000000", {ce, pend, cfg_err});
        end
        reset    = 1'b0;
        pause    = 1'b0;
        align    = 1'b0;
        cfg_load = 2'b00;
        for (int i = 1; i <= 12; i++) begin
            step();
            exp = (i % 6 == 0) ? 2'b11 : 2'b00;
            n_cmp++;
            if (ce !== exp) begin
                n_fail++;
                $display("FAIL reset_first_pulse step %0d: ce=%b required %b", i, ce, exp);
            end
        end
    endtask

    task automatic test_defaults();
        int c0, c1, bad;
        do_reset();
        cfg_num  = 16'h0100;
        cfg_den  = 16'h0200;
        cfg_load = 2'b10;
        step();
        n_cmp++;
        if (pend !== 2'b10) begin
            n_fail++;
            $display("FAIL defaults_pend_set: pend=%b required 10", pend);
        end
        cfg_load = 2'b00;
        align    = 1'b1;
        step();
        align    = 1'b0;
        n_cmp++;
        if (pend !== 2'b00) begin
            n_fail++;
            $display("FAIL defaults_pend_clear: pend=%b required 00", pend);
        end
        c0  = 0;
        c1  = 0;
        bad = 0;
        for (int i = 1; i <= 1000; i++) begin
            step();
            if (ce[0] === 1'b1) c0++;
            if (ce[1] === 1'b1) c1++;
            if (ce[0] !== (i % 6 == 0) || ce[1] !== (i % 2 == 0)) bad++;
        end
        n_cmp++;
        if (c0 !== 166) begin
            n_fail++;
            $display("FAIL defaults_count_ch0: got %0d required 166", c0);
        end
        n_cmp++;
        if (c1 !== 500) begin
            n_fail++;
            $display("FAIL defaults_count_ch1: got %0d required 500", c1);
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL defaults_spacing: %0d misplaced cycles required 0", bad);
        end
    endtask

    task automatic test_switch();
        logic [1:0] exp_ce;
        logic       exp_pend;
        do_reset();
        cfg_num = 16'h0001;
        cfg_den = 16'h0004;
        for (int i = 1; i <= 24; i++) begin
            cfg_load = (i == 9) ? 2'b01 : 2'b00;
            step();
            exp_ce[0] = (i == 6 || i == 12 || i == 16 || i == 20 || i == 24);
            exp_ce[1] = (i % 6 == 0);
            exp_pend  = (i >= 9 && i <= 11);
            n_cmp++;
            if (ce !== exp_ce || pend[0] !== exp_pend) begin
                n_fail++;
                $display("FAIL switch step %0d: ce=%b pend0=%b required ce=%b pend0=%b",
                         i, ce, pend[0], exp_ce, exp_pend);
            end
        end
        cfg_load = 2'b00;
    endtask

    task automatic test_fractional();
        int cnt, last, bad;
        do_reset();
        load_apply(2'b01, 16'h0003, 16'h0008);
        cnt  = 0;
        last = 0;
        bad  = 0;
        for (int i = 1; i <= 80; i++) begin
            step();
            if (ce[0] === 1'b1) begin
                cnt++;
                if ((i - last) != 2 && (i - last) != 3) bad++;
                last = i;
            end
        end
        n_cmp++;
        if (cnt !== 30) begin
            n_fail++;
            $display("FAIL frac_count: got %0d required 30", cnt);
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL frac_gaps: %0d gaps outside 2..3 required 0", bad);
        end
    endtask

    task automatic test_pause();
        int cnt;
        logic exp;
        do_reset();
        load_apply(2'b01, 16'h0001, 16'h0004);
        cnt = 0;
        step();
        step();
        if (ce[0] === 1'b1) cnt++;
        pause = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            n_cmp++;
            if (ce !== 2'b00) begin
                n_fail++;
                $display("FAIL pause_silent cycle %0d: ce=%b required 00", i, ce);
            end
        end
        pause = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            step();
            exp = (j == 2 || j == 6 || j == 10);
            if (ce[0] === 1'b1) cnt++;
            n_cmp++;
            if (ce[0] !== exp) begin
                n_fail++;
                $display("FAIL pause_resume step %0d: ce0=%b required %b", j, ce[0], exp);
            end
        end
        n_cmp++;
        if (cnt !== 3) begin
            n_fail++;
            $display("FAIL pause_total: got %0d required 3", cnt);
        end
    endtask

    task automatic test_invalid();
        do_reset();
        load_apply(2'b01, 16'h0001, 16'h0000);
        n_cmp++;
        if (cfg_err !== 2'b01) begin
            n_fail++;
            $display("FAIL inv_den0_err: cfg_err=%b required 01", cfg_err);
        end
        for (int i = 1; i <= 5; i++) begin
            step();
            n_cmp++;
            if (ce[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL inv_den0_silent step %0d: ce0=%b required 0", i, ce[0]);
            end
        end
        cfg_num  = 16'h0001;
        cfg_den  = 16'h0001;
        cfg_load = 2'b01;
        step();
        cfg_load = 2'b00;
        step();
        n_cmp++;
        if (pend[0] !== 1'b0 || cfg_err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_recover_apply: pend0=%b err0=%b required 0 0", pend[0], cfg_err[0]);
        end
        for (int i = 1; i <= 5; i++) begin
            step();
            n_cmp++;
            if (ce[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL inv_one_over_one step %0d: ce0=%b required 1", i, ce[0]);
            end
        end
        cfg_num  = 16'h0005;
        cfg_den  = 16'h0003;
        cfg_load = 2'b01;
        step();
        cfg_load = 2'b00;
        step();
        n_cmp++;
        if (cfg_err[0] !== 1'b1 || pend[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_num_gt_den: err0=%b pend0=%b required 1 0", cfg_err[0], pend[0]);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            n_cmp++;
            if (ce[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL inv_num_gt_den_silent step %0d: ce0=%b required 0", i, ce[0]);
            end
        end
    endtask

    task automatic test_align_reset();
        logic [1:0] exp;
        do_reset();
        load_apply(2'b11, 16'h0101, 16'h0604);
        for (int i = 1; i <= 22; i++) begin
            align = (i == 4 || i == 16);
            step();
            exp[0] = (i % 4 == 0 && i <= 20);
            exp[1] = (i == 10 || i == 16 || i == 22);
            n_cmp++;
            if (ce !== exp) begin
                n_fail++;
                $display("FAIL align step %0d: ce=%b required %b", i, ce, exp);
            end
        end
        align    = 1'b0;
        cfg_num  = 16'h0200;
        cfg_den  = 16'h0400;
        cfg_load = 2'b10;
        step();
        cfg_load = 2'b00;
        n_cmp++;
        if (pend !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_pend_set: pend=%b required 10", pend);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++;
        if (pend !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_pend_clear: pend=%b required 00", pend);
        end
        for (int i = 1; i <= 12; i++) begin
            step();
            exp = (i % 6 == 0) ? 2'b11 : 2'b00;
            n_cmp++;
            if (ce !== exp) begin
                n_fail++;
                $display("FAIL rst_restore step %0d: ce=%b required %b", i, ce, exp);
            end
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        reset    = 1'b1;
        pause    = 1'b0;
        align    = 1'b0;
        cfg_load = 2'b00;
        cfg_num  = 16'h0000;
        cfg_den  = 16'h0000;
        test_reset();
        test_defaults();
        test_switch();
        test_fractional();
        test_pause();
        test_invalid();
        test_align_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
